toggle_decoder: RTL and testbench

Receive-side decoder for two-phase (toggle) signalling. The sender drives a line from a toggle flip-flop, and every level change of that line is one event. This block synchronises the line into the local clock domain and turns each transition into a counted pending event. It presents the events to a local consumer over a valid/ready handshake and returns a toggle-encoded acknowledge to the sender for every event consumed.

---
 rtl/toggle_decoder.sv | 69 ++++++
 tb/tb_toggle_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/toggle_decoder.sv
// Receive-side decoder for two-phase (toggle) signalling: synchronises t_in, counts each
// transition as a pending event, and returns a toggle acknowledge per consumed event.
module toggle_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             t_in,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CNT_W-1:0] pending,
    output logic             ack,
    output logic             overflow,
    input  logic             clear
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       pending_q;
    logic                   ack_q;
    logic                   overflow_q;

    logic ev_edge;
    logic consume;
    logic saturated;
    logic ovf_set;

    assign ev_edge   = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign consume   = ev_valid && ev_ready;
    assign saturated = (pending_q == {CNT_W{1'b1}});
    // A simultaneous consume frees a slot, so a saturated edge is only lost without one.
    assign ovf_set   = ev_edge && !consume && saturated;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            pending_q  <= '0;
            ack_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
            prev_q <= sync_q[SYNC_STAGES-1];

            if (ev_edge && !consume && !saturated) begin
                pending_q <= pending_q + 1'b1;
            end else if (consume && !ev_edge) begin
                pending_q <= pending_q - 1'b1;
            end

            if (consume) begin
                ack_q <= ~ack_q;
            end

            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (clear) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign pending  = pending_q;
    assign ev_valid = (pending_q != '0);
    assign ack      = ack_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed, table-driven bench for toggle_decoder (default parameters).
module tb_toggle_decoder;

    logic       clock;
    logic       reset;
    logic       t_in;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] pending;
    logic       ack;
    logic       overflow;
    logic       clear;

    int checks;
    int errors;

    toggle_decoder #(
        .SYNC_STAGES(2),
        .CNT_W      (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .t_in    (t_in),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .pending (pending),
        .ack     (ack),
        .overflow(overflow),
        .clear   (clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       t;
        logic       rdy;
        logic [3:0] p;
        logic       v;
        logic       a;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string name, input int p, input int v, input int a,
                             input int o);
        check({name, " pending"}, int'(pending), p);
        check({name, " ev_valid"}, int'(ev_valid), v);
        check({name, " ack"}, int'(ack), a);
        check({name, " overflow"}, int'(overflow), o);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        t_in     = 1'b0;
        ev_ready = 1'b0;
        clear    = 1'b0;

        // Single event, then consume; a ready with nothing pending does nothing.
        vecs[0]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'd1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
        // Falling, rising, falling transitions, three clocks per level.
        vecs[5]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 4'd1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 4'd1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 4'd1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 4'd2, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 4'd2, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 4'd2, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 4'd3, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 4'd3, 1'b1, 1'b1};
        // Drain three events.
        vecs[15] = '{1'b0, 1'b1, 4'd2, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 4'd1, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0};

        // Reset held while t_in toggles.
        for (int i = 0; i < 6; i++) begin
            #7 t_in = ~t_in;
            check_all("in_reset", 0, 0, 0, 0);
        end
        t_in = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_all("idle", 0, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            t_in     = vecs[i].t;
            ev_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d pending", i), int'(pending), int'(vecs[i].p));
            check($sformatf("vec%0d ev_valid", i), int'(ev_valid), int'(vecs[i].v));
            check($sformatf("vec%0d ack", i), int'(ack), int'(vecs[i].a));
            check($sformatf("vec%0d overflow", i), int'(overflow), 0);
        end

        // Saturation: 16 events into a 15-deep counter.
        ev_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            t_in = ~t_in;
            tick();
            tick();
        end
        tick();
        tick();
        check_all("saturate", 15, 1, 0, 1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_all("clear", 15, 1, 0, 0);

        // Clear held across a saturated edge: set wins.
        clear = 1'b1;
        t_in  = ~t_in;
        tick();
        tick();
        check("clear_pre_edge overflow", int'(overflow), 0);
        tick();
        clear = 1'b0;
        check_all("set_wins", 15, 1, 0, 1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("reclear overflow", int'(overflow), 0);

        // Edge and consume in the same cycle at saturation.
        t_in = ~t_in;
        tick();
        tick();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check_all("edge_and_consume", 15, 1, 1, 0);

        // Drain to 5, then asynchronous reset between edges.
        ev_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        ev_ready = 1'b0;
        check_all("drain_to_5", 5, 1, 1, 0);

        t_in = 1'b1;
        #2 reset = 1'b0;
        #1 check_all("async_reset", 0, 0, 0, 0);
        @(posedge clock);
        #1 check_all("reset_held", 0, 0, 0, 0);

        // Release with t_in high: counted as one event two edges after capture.
        reset = 1'b1;
        tick();
        tick();
        check("release_early pending", int'(pending), 0);
        tick();
        check_all("release_t_high", 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
